debug_dump_tx: RTL and testbench
================================

Name: debug_dump_tx

Overview:
- Host-side reader for the pipeline's exposed debug state: PC, the 32-word register file image and the 10-word data-memory image.
- On a dump request, captures a coherent snapshot in one cycle.
- Serialises the snapshot as a checksummed byte frame over a valid/ready byte stream, which feeds the team's UART transmitter.
- Sits between the pipeline top and the UART TX.

Parameters:
- NUM_REGS, 32, number of 32-bit register words in the snapshot.
- NUM_MEM_WORDS, 10, number of 32-bit data-memory words in the snapshot.
- PC_WIDTH, 10, width of the captured PC (at most 16).
- HEADER_BYTE, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- dump_req  input  1  single-cycle request to capture and send a frame.
- pc_in  input  PC_WIDTH  current PC from the pipeline.
- regs_in  input  32*NUM_REGS  register file image; word i is bits [32i+31:32i].
- mem_in  input  32*NUM_MEM_WORDS  data memory image; same packing as regs_in.
- tx_data  output  8  byte presented to the UART TX.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  UART TX accepts the byte this cycle.
- busy  output  1  a frame is being captured or sent.
- frame_done  output  1  one-cycle pulse after the checksum byte is accepted.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state to IDLE;
  - tx_data, tx_valid, busy and frame_done to 0;
  - byte counter and checksum to 0;
  - snapshot registers to 0.
- Frame layout, FRAME_LEN = 4 + 4*NUM_REGS + 4*NUM_MEM_WORDS (172 bytes at defaults). Byte order:
  - HEADER_BYTE;
  - PC high byte, then PC low byte (PC zero-extended to 16 bits);
  - reg0..regN-1, each sent big-endian, MSB byte first;
  - mem0..memM-1, big-endian;
  - checksum = XOR of all preceding frame bytes, header included.
- Handshake:
  - A byte transfers on a rising edge where tx_valid and tx_ready are both 1.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable.
  - tx_valid never drops without a transfer, except on reset.
- State machine:
  - IDLE: busy=0, tx_valid=0. If dump_req=1, latch pc_in/regs_in/mem_in into the snapshot, clear the counter and checksum, and go to SEND.
  - SEND: busy=1, tx_valid=1, tx_data = byte selected by the counter from the snapshot. On each transfer, checksum ^= tx_data and the counter increments. A transfer at counter FRAME_LEN-2 moves to CSUM.
  - CSUM: tx_data = checksum register. On transfer go to DONE.
  - DONE: frame_done=1 and busy=1 for exactly one cycle, then IDLE.
- Latency:
  - dump_req at edge N gives tx_valid=1 with the header from edge N+1.
  - With tx_ready held at 1, the frame completes in FRAME_LEN cycles; frame_done is the following cycle.
- dump_req while busy=1 is ignored; it is not queued. A request in the same cycle DONE returns to IDLE is also ignored.
- The snapshot is frozen for the whole frame, so input changes during transmission do not alter the frame.
- The byte counter is 8 bits wide when FRAME_LEN ≤ 256, otherwise wide enough for FRAME_LEN-1. The counter never wraps within a frame.
- Reset mid-frame aborts immediately: tx_valid drops asynchronously, and no partial checksum is sent.

Decomposition:
- Shared package dbg_pkg holds:
  - the state enum (IDLE, SEND, CSUM, DONE);
  - the HEADER_BYTE default;
  - FRAME_LEN and counter-width functions of NUM_REGS/NUM_MEM_WORDS;
  - the field offset constants (PC_OFS=1, REG_OFS=3, MEM_OFS=3+4*NUM_REGS).
- One sub-module is natural: dump_byte_sel, a purely combinational mapping of counter plus snapshot to an output byte (header, PC, reg or mem field). The FSM, counter, checksum and snapshot stay in the top.

Test Plan:
- Reset: assert reset mid-cycle -> all outputs 0 immediately (asynchronous); after release with no dump_req, tx_valid stays 0 for 100 cycles.
- Basic dump, tx_ready=1:
  - Stimulus: pc=10'h3FF, reg i = 32'h0100_0000*i + i, mem j = 32'hDEAD_0000 + j.
  - Required: 172 bytes, starting A5 03 FF 00 00 00 00 01 00 00 01 …; last byte equals XOR of the previous 171; frame_done pulses the cycle after.
- Backpressure: toggle tx_ready pseudo-randomly, with a 20-cycle stall at byte 50 -> tx_data constant through the stall, no byte lost or duplicated, same frame as the basic dump.
- Snapshot coherence and ignored request:
  - Change regs_in every cycle and pulse dump_req at byte 10.
  - Required: frame equals the inputs at the capture edge; exactly one frame sent; busy high throughout.
- Reset mid-frame: assert reset at byte 90 -> tx_valid=0 at once; a new dump_req then yields a complete, correct frame starting with A5.
- Parameter corner: NUM_REGS=1, NUM_MEM_WORDS=1 -> FRAME_LEN=12; with all-zero data, checksum byte = A5 ^ PC bytes.

Source files
------------

// File: rtl/debug_dump_tx_pkg.sv
`default_nettype none
// ==== dbg_pkg : state type and frame geometry for debug_dump_tx (rev 1.0) ====
package dbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  localparam int PC_OFS  = 1;
  localparam int REG_OFS = 3;

  function automatic int mem_ofs(input int num_regs);
    return REG_OFS + 4 * num_regs;
  endfunction

  // Header + two PC bytes + payload + trailing checksum.
  function automatic int frame_len(input int num_regs, input int num_mem_words);
    return 4 + 4 * num_regs + 4 * num_mem_words;
  endfunction

  function automatic int cnt_width(input int num_regs, input int num_mem_words);
    int len;
    len = frame_len(num_regs, num_mem_words);
    if (len <= 256) return 8;
    return $clog2(len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_dump_tx_byte_sel.sv
`default_nettype none
// ==== dump_byte_sel : maps frame byte position onto snapshot fields (rev 1.0) ====
module dump_byte_sel
  import dbg_pkg::*;
#(
  parameter int         NUM_REGS      = 32,
  parameter int         NUM_MEM_WORDS = 10,
  parameter int         PC_WIDTH      = 10,
  parameter logic [7:0] HEADER_BYTE   = HEADER_BYTE_DEFAULT,
  parameter int         CNT_W         = 8
) (
  input  logic [CNT_W-1:0]            cnt,
  input  logic [PC_WIDTH-1:0]         pc,
  input  logic [32*NUM_REGS-1:0]      regs,
  input  logic [32*NUM_MEM_WORDS-1:0] mem,
  output logic [7:0]                  sel_byte
);

  localparam int MEM_OFS   = mem_ofs(NUM_REGS);
  localparam int FRAME_LEN = frame_len(NUM_REGS, NUM_MEM_WORDS);
  localparam int REG_BIT_W = $clog2(32 * NUM_REGS);
  localparam int MEM_BIT_W = $clog2(32 * NUM_MEM_WORDS);

  logic [15:0]          pc16;
  logic [REG_BIT_W-1:0] reg_bit;
  logic [MEM_BIT_W-1:0] mem_bit;
  int                   pos;
  int                   rel;

  generate
    if (PC_WIDTH < 16) begin : g_pc_pad
      assign pc16 = {{(16 - PC_WIDTH){1'b0}}, pc};
    end else begin : g_pc_full
      assign pc16 = pc[15:0];
    end
  endgenerate

  // Inverting the two low bits of the field-relative index turns
  // "byte b of word w, MSB first" into the little-endian byte lane.
  always_comb begin
    pos      = int'(cnt);
    rel      = 0;
    reg_bit  = '0;
    mem_bit  = '0;
    sel_byte = 8'h00;
    if (pos == 0) begin
      sel_byte = HEADER_BYTE;
    end else if (pos == PC_OFS) begin
      sel_byte = pc16[15:8];
    end else if (pos < REG_OFS) begin
      sel_byte = pc16[7:0];
    end else if (pos < MEM_OFS) begin
      rel      = pos - REG_OFS;
      reg_bit  = REG_BIT_W'(8 * (rel ^ 3));
      sel_byte = regs[reg_bit +: 8];
    end else if (pos < FRAME_LEN - 1) begin
      rel      = pos - MEM_OFS;
      mem_bit  = MEM_BIT_W'(8 * (rel ^ 3));
      sel_byte = mem[mem_bit +: 8];
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_dump_tx.sv
`default_nettype none
// ==== debug_dump_tx : snapshot capture and checksummed byte-frame sender (rev 1.0) ====
module debug_dump_tx
  import dbg_pkg::*;
#(
  parameter int         NUM_REGS      = 32,
  parameter int         NUM_MEM_WORDS = 10,
  parameter int         PC_WIDTH      = 10,
  parameter logic [7:0] HEADER_BYTE   = HEADER_BYTE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dump_req,
  input  logic [PC_WIDTH-1:0]           pc_in,
  input  logic [32*NUM_REGS-1:0]        regs_in,
  input  logic [32*NUM_MEM_WORDS-1:0]   mem_in,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int               FRAME_LEN     = frame_len(NUM_REGS, NUM_MEM_WORDS);
  localparam int               CNT_W         = cnt_width(NUM_REGS, NUM_MEM_WORDS);
  localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(FRAME_LEN - 2);

  dump_state_t                   state;
  dump_state_t                   state_nxt;
  logic [CNT_W-1:0]              byte_cnt;
  logic [7:0]                    csum;
  logic [PC_WIDTH-1:0]           snap_pc;
  logic [32*NUM_REGS-1:0]        snap_regs;
  logic [32*NUM_MEM_WORDS-1:0]   snap_mem;
  logic [7:0]                    field_byte;
  logic                          capture;
  logic                          xfer;

  assign capture = (state == IDLE) && dump_req;
  assign xfer    = tx_valid && tx_ready;

  dump_byte_sel #(
    .NUM_REGS      (NUM_REGS),
    .NUM_MEM_WORDS (NUM_MEM_WORDS),
    .PC_WIDTH      (PC_WIDTH),
    .HEADER_BYTE   (HEADER_BYTE),
    .CNT_W         (CNT_W)
  ) u_byte_sel (
    .cnt      (byte_cnt),
    .pc       (snap_pc),
    .regs     (snap_regs),
    .mem      (snap_mem),
    .sel_byte (field_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dump_req) state_nxt = SEND;
      SEND:    if (xfer && (byte_cnt == LAST_DATA_CNT)) state_nxt = CSUM;
      CSUM:    if (xfer) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset clears them without a clock.
  always_comb begin
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = field_byte;
      end
      CSUM: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = csum;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_pc   <= '0;
      snap_regs <= '0;
      snap_mem  <= '0;
    end else if (capture) begin
      snap_pc   <= pc_in;
      snap_regs <= regs_in;
      snap_mem  <= mem_in;
    end
  end

  // Counter parks at FRAME_LEN-1 during CSUM; only data bytes feed the checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      csum     <= 8'h00;
    end else if (capture) begin
      byte_cnt <= '0;
      csum     <= 8'h00;
    end else if ((state == SEND) && xfer) begin
      byte_cnt <= byte_cnt + CNT_W'(1);
      csum     <= csum ^ field_byte;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_dump_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ==== tb_debug_dump_tx : directed vectors for debug_dump_tx (rev 1.0) ====
module tb_debug_dump_tx;

  localparam int NR = 32;
  localparam int NM = 10;
  localparam int PW = 10;
  localparam int FL = 4 + 4 * NR + 4 * NM;

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } vec_t;

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              dump_req = 1'b0;
  logic              tx_ready = 1'b1;
  logic [PW-1:0]     pc_in    = '0;
  logic [32*NR-1:0]  regs_in  = '0;
  logic [32*NM-1:0]  mem_in   = '0;
  logic [7:0]        tx_data;
  logic              tx_valid, busy, frame_done;

  logic              dump_req2 = 1'b0;
  logic              tx_ready2 = 1'b1;
  logic [PW-1:0]     pc2       = '0;
  logic [31:0]       regs2     = '0;
  logic [31:0]       mem2      = '0;
  logic [7:0]        tx_data2;
  logic              tx_valid2, busy2, frame_done2;

  always #5 clk = ~clk;

  debug_dump_tx #(.NUM_REGS(NR), .NUM_MEM_WORDS(NM), .PC_WIDTH(PW), .HEADER_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .dump_req(dump_req), .pc_in(pc_in), .regs_in(regs_in),
    .mem_in(mem_in), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done));

  debug_dump_tx #(.NUM_REGS(1), .NUM_MEM_WORDS(1), .PC_WIDTH(PW), .HEADER_BYTE(8'hA5)) dut_small (
    .clk(clk), .reset(reset), .dump_req(dump_req2), .pc_in(pc2), .regs_in(regs2),
    .mem_in(mem2), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .busy(busy2), .frame_done(frame_done2));

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rx_q[$];
  logic [7:0] rx2_q[$];
  logic [7:0] exp_q[$];
  int cyc = 0, last_xfer_cyc = 0, fd_cyc = 0, fd_count = 0, fd2_count = 0, hold_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_valid && tx_ready) begin
      rx_q.push_back(tx_data);
      last_xfer_cyc <= cyc;
    end
    if (frame_done) begin
      fd_cyc   <= cyc;
      fd_count <= fd_count + 1;
    end
    if (prev_stall && (!tx_valid || tx_data !== prev_data)) hold_err <= hold_err + 1;
    prev_stall <= tx_valid && !tx_ready;
    prev_data  <= tx_data;
  end

  always @(posedge clk) begin
    if (tx_valid2 && tx_ready2) rx2_q.push_back(tx_data2);
    if (frame_done2) fd2_count <= fd2_count + 1;
  end

  logic [31:0]   m_regs[NR];
  logic [31:0]   m_mem[NM];
  logic [PW-1:0] m_pc;
  logic [31:0]   c_regs[NR];
  logic [31:0]   c_mem[NM];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_exp();
    logic [15:0] p;
    logic [7:0]  x;
    p = 16'(m_pc);
    exp_q = {};
    exp_q.push_back(8'hA5);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[7:0]);
    for (int i = 0; i < NR; i++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(m_regs[i][8*b +: 8]);
    for (int j = 0; j < NM; j++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(m_mem[j][8*b +: 8]);
    x = 8'h00;
    foreach (exp_q[k]) x = x ^ exp_q[k];
    exp_q.push_back(x);
  endtask

  task automatic drive_model();
    pc_in = m_pc;
    for (int i = 0; i < NR; i++) regs_in[32*i +: 32] = m_regs[i];
    for (int j = 0; j < NM; j++) mem_in[32*j +: 32] = m_mem[j];
  endtask

  task automatic basic_pattern(input logic [PW-1:0] pc);
    m_pc = pc;
    for (int i = 0; i < NR; i++) m_regs[i] = 32'(i) * 32'h0100_0000 + 32'(i);
    for (int j = 0; j < NM; j++) m_mem[j] = 32'hDEAD_0000 + 32'(j);
  endtask

  task automatic compare_frame(input string name);
    int bi;
    bi = 0;
    check({name, " length"}, rx_q.size(), exp_q.size());
    for (int k = exp_q.size() - 1; k >= 0; k--)
      if (k < rx_q.size() && rx_q[k] !== exp_q[k]) bi = k;
    check($sformatf("%s byte %0d", name, bi), (bi < rx_q.size()) ? rx_q[bi] : 8'hxx, exp_q[bi]);
  endtask

  task automatic request(input string name);
    @(negedge clk);
    dump_req = 1'b1;
    @(posedge clk);
    #1;
    dump_req = 1'b0;
    check({name, " valid after req"}, tx_valid, 1'b1);
    check({name, " header after req"}, tx_data, 8'hA5);
  endtask

  task automatic wait_frame(input string name, input int bound);
    int start;
    start = fd_count;
    for (int k = 0; k < bound && fd_count == start; k++) begin
      @(posedge clk);
      #1;
    end
    check({name, " frame_done seen"}, fd_count - start, 1);
  endtask

  vec_t basic_tab[16];
  vec_t small_tab[12];

  initial begin
    int start, idle_hi, busy_bad, stall_left;
    logic stalled, second;
    logic [7:0] x;

    basic_tab[0]  = '{0,   8'hA5}; basic_tab[1]  = '{1,   8'h03};
    basic_tab[2]  = '{2,   8'hFF}; basic_tab[3]  = '{3,   8'h00};
    basic_tab[4]  = '{6,   8'h00}; basic_tab[5]  = '{7,   8'h01};
    basic_tab[6]  = '{10,  8'h01}; basic_tab[7]  = '{11,  8'h02};
    basic_tab[8]  = '{14,  8'h02}; basic_tab[9]  = '{127, 8'h1F};
    basic_tab[10] = '{130, 8'h1F}; basic_tab[11] = '{131, 8'hDE};
    basic_tab[12] = '{132, 8'hAD}; basic_tab[13] = '{134, 8'h00};
    basic_tab[14] = '{170, 8'h09}; basic_tab[15] = '{171, 8'h58};
    small_tab[0] = '{0, 8'hA5}; small_tab[1] = '{1, 8'h02}; small_tab[2] = '{2, 8'hC5};
    for (int k = 3; k < 11; k++) small_tab[k] = '{k, 8'h00};
    small_tab[11] = '{11, 8'h62};

    // Reset state and quiet idle
    #1;
    check("reset tx_valid", tx_valid, 1'b0);
    check("reset tx_data", tx_data, 8'h00);
    check("reset busy", busy, 1'b0);
    check("reset frame_done", frame_done, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    idle_hi = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx_valid || busy) idle_hi++;
    end
    check("idle no traffic", idle_hi, 0);

    // Basic dump, ready held high
    basic_pattern(10'h3FF);
    drive_model();
    build_exp();
    rx_q = {};
    start = fd_count;
    request("basic");
    wait_frame("basic", 400);
    for (int v = 0; v < 16; v++)
      check($sformatf("basic tab byte %0d", basic_tab[v].idx), rx_q[basic_tab[v].idx], basic_tab[v].exp);
    x = 8'h00;
    for (int k = 0; k < FL - 1; k++) x = x ^ rx_q[k];
    check("basic checksum xor", rx_q[FL-1], x);
    compare_frame("basic");
    check("basic done timing", fd_cyc, last_xfer_cyc + 1);
    @(posedge clk); #1;
    check("basic done width", fd_count - start, 1);
    check("basic idle after", busy, 1'b0);

    // Backpressure with a long stall at byte 50
    rx_q = {};
    stalled = 1'b0;
    stall_left = 0;
    start = fd_count;
    request("bp");
    for (int k = 0; k < 3000 && fd_count == start; k++) begin
      @(negedge clk);
      if (stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else if (!stalled && rx_q.size() == 50) begin
        stalled = 1'b1;
        stall_left = 19;
        tx_ready = 1'b0;
      end else begin
        tx_ready = 1'($urandom_range(0, 1));
      end
    end
    tx_ready = 1'b1;
    check("bp frame_done seen", fd_count - start, 1);
    check("bp stall exercised", stalled, 1'b1);
    check("bp data held while stalled", hold_err, 0);
    compare_frame("bp");

    // Coherence: inputs churn every cycle, second request mid-frame is dropped
    rx_q = {};
    start = fd_count;
    second = 1'b0;
    busy_bad = 0;
    for (int k = 0; k < 800 && fd_count == start; k++) begin
      @(negedge clk);
      if (k > 3 && fd_count == start && !busy) busy_bad++;
      for (int i = 0; i < NR; i++) c_regs[i] = {16'(k), 16'(i)} ^ 32'h5A5A_0000;
      for (int j = 0; j < NM; j++) c_mem[j] = {16'(j), 16'(k)};
      pc_in = PW'(k * 7 + 1);
      for (int i = 0; i < NR; i++) regs_in[32*i +: 32] = c_regs[i];
      for (int j = 0; j < NM; j++) mem_in[32*j +: 32] = c_mem[j];
      dump_req = (k == 3) || (!second && rx_q.size() == 10);
      if (!second && rx_q.size() == 10) second = 1'b1;
      if (k == 3) begin
        m_pc = pc_in;
        for (int i = 0; i < NR; i++) m_regs[i] = c_regs[i];
        for (int j = 0; j < NM; j++) m_mem[j] = c_mem[j];
      end
    end
    dump_req = 1'b0;
    repeat (30) @(negedge clk);
    build_exp();
    check("coh second req issued", second, 1'b1);
    check("coh single frame", fd_count - start, 1);
    check("coh busy throughout", busy_bad, 0);
    compare_frame("coh");

    // Reset mid-frame, then a clean frame
    basic_pattern(10'h155);
    drive_model();
    rx_q = {};
    request("abort");
    for (int k = 0; k < 500 && rx_q.size() < 90; k++) @(negedge clk);
    start = fd_count;
    #2 reset = 1'b1;
    #1;
    check("abort tx_valid async", tx_valid, 1'b0);
    check("abort busy async", busy, 1'b0);
    check("abort tx_data async", tx_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    check("abort no done pulse", fd_count - start, 0);
    check("abort bytes before reset", rx_q.size(), 90);
    m_pc = 10'h2A3;
    for (int i = 0; i < NR; i++) m_regs[i] = ~(32'(i) * 32'h0011_2233);
    for (int j = 0; j < NM; j++) m_mem[j] = 32'h1357_9BDF ^ 32'(j << 4);
    drive_model();
    build_exp();
    rx_q = {};
    request("after abort");
    wait_frame("after abort", 400);
    compare_frame("after abort");

    // Small geometry: one register, one memory word
    pc2 = 10'h2C5;
    start = fd2_count;
    @(negedge clk);
    dump_req2 = 1'b1;
    @(negedge clk);
    dump_req2 = 1'b0;
    for (int k = 0; k < 100 && fd2_count == start; k++) @(negedge clk);
    check("small frame_done seen", fd2_count - start, 1);
    check("small length", rx2_q.size(), 12);
    for (int v = 0; v < 12; v++)
      check($sformatf("small byte %0d", small_tab[v].idx), rx2_q[small_tab[v].idx], small_tab[v].exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
